pll_lock_sequencer: RTL

- Runs on the free-running 10 MHz PLL reference clock and supervises the board PLL that generates the 25 MHz and 125 MHz system clocks.
- Drives the PLL reset and watches its asynchronous lock indication. Requires lock to be stable before releasing the downstream system reset.
- On loss of lock or lock timeout, re-resets the PLL and counts the events for the register file.

---
 rtl/pll_seq_pkg.sv | 19 +
 rtl/bit_sync_2ff.sv | 32 +++
 rtl/pll_lock_sequencer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and default timing constants for the PLL lock sequencer.
package pll_seq_pkg;

  // Sequencer states; the codes are visible on state_o.
  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } pll_state_e;

  // Defaults for a 10 MHz reference clock.
  localparam int DEF_PLL_RST_CYCLES      = 16;      // 1.6 us PLL reset pulse
  localparam int DEF_LOCK_STABLE_CYCLES  = 1000;    // 100 us of continuous lock
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 100000;  // 10 ms to acquire lock
  localparam int DEF_CNT_W               = 17;      // holds 100000-1
  localparam int DEF_EVT_W               = 8;

endpackage

// File: rtl/bit_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous status bit.
// Output follows the input two clock edges later; both flops clear to 0 in reset.
module bit_sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Shift the asynchronous bit through the two stages.
  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  // Synchronizer flops with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Supervises the board PLL: pulses its reset, waits for a stable lock, then
// releases the downstream system reset. Lock losses and lock timeouts restart
// the PLL and are counted in saturating event counters.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int CNT_W               = DEF_CNT_W,
  parameter int EVT_W               = DEF_EVT_W
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             pll_locked_i,
  input  logic             force_relock_i,
  output logic             pll_rst_o,
  output logic             sys_rst_n_o,
  output logic             ready_o,
  output logic [1:0]       state_o,
  output logic [EVT_W-1:0] lock_loss_cnt_o,
  output logic [EVT_W-1:0] timeout_cnt_o
);

  // Terminal counts: each phase ends on the edge where cnt holds its last value.
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [EVT_W-1:0] EVT_MAX      = {EVT_W{1'b1}};

  pll_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [EVT_W-1:0] lock_loss_q, lock_loss_d;
  logic [EVT_W-1:0] timeout_q, timeout_d;
  logic             pll_rst_q, pll_rst_d;
  logic             sys_rst_n_q, sys_rst_n_d;
  logic             ready_q, ready_d;
  logic             locked_s;

  bit_sync_2ff u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d_i   (pll_locked_i),
    .q_o   (locked_s)
  );

  // Next-state, cycle counter and event counters. force_relock_i outranks
  // every other condition; cnt restarts on any transition.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    lock_loss_d = lock_loss_q;
    timeout_d   = timeout_q;
    case (state_q)
      PLL_RESET: begin
        if (force_relock_i) begin
          cnt_d = '0;
        end else if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      WAIT_LOCK: begin
        if (force_relock_i) begin
          state_d = PLL_RESET;
          cnt_d   = '0;
        end else if (locked_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = PLL_RESET;
          cnt_d   = '0;
          if (timeout_q != EVT_MAX) timeout_d = timeout_q + 1'b1;
        end
      end
      STABLE: begin
        if (force_relock_i) begin
          state_d = PLL_RESET;
          cnt_d   = '0;
        end else if (!locked_s) begin
          // Lock wobbled before it proved stable: restart the timeout window.
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (force_relock_i) begin
          state_d = PLL_RESET;
          cnt_d   = '0;
        end else if (!locked_s) begin
          state_d = PLL_RESET;
          cnt_d   = '0;
          if (lock_loss_q != EVT_MAX) lock_loss_d = lock_loss_q + 1'b1;
        end
      end
      default: begin
        state_d = PLL_RESET;
        cnt_d   = '0;
      end
    endcase
  end

  // Moore outputs decoded from the next state so they are registered with it.
  always_comb begin
    pll_rst_d   = (state_d == PLL_RESET);
    sys_rst_n_d = (state_d == RUN);
    ready_d     = (state_d == RUN);
  end

  // State, counter and output registers; reset holds the PLL and system in reset.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_q     <= PLL_RESET;
      cnt_q       <= '0;
      lock_loss_q <= '0;
      timeout_q   <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lock_loss_q <= lock_loss_d;
      timeout_q   <= timeout_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
    end
  end

  assign pll_rst_o       = pll_rst_q;
  assign sys_rst_n_o     = sys_rst_n_q;
  assign ready_o         = ready_q;
  assign state_o         = state_q;
  assign lock_loss_cnt_o = lock_loss_q;
  assign timeout_cnt_o   = timeout_q;

endmodule
